// File: rtl/logic_unit.sv
// Registered, handshaked bitwise logic unit: per-beat results or a result
// folded across a multi-beat accumulate burst, with reduction and beat count.
module logic_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             in_acc,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             q_red,
  output logic [CNT_W-1:0] beat_cnt
);

  typedef enum logic {
    S_IDLE,
    S_ACC
  } state_t;

  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_XOR    = 3'd2,
    OP_NAND   = 3'd3,
    OP_NOR    = 3'd4,
    OP_XNOR   = 3'd5,
    OP_ANDNOT = 3'd6,
    OP_PASS   = 3'd7
  } op_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [WIDTH-1:0] apply_op(input op_t o,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    r = x;
    case (o)
      OP_AND:    r = x & y;
      OP_OR:     r = x | y;
      OP_XOR:    r = x ^ y;
      OP_NAND:   r = ~(x & y);
      OP_NOR:    r = ~(x | y);
      OP_XNOR:   r = ~(x ^ y);
      OP_ANDNOT: r = x & ~y;
      OP_PASS:   r = x;
      default:   r = x;
    endcase
    return r;
  endfunction

  // Reduction follows the op family, not the literal op.
  function automatic logic reduce_op(input op_t o, input logic [WIDTH-1:0] v);
    logic r;
    case (o)
      OP_OR, OP_NOR:   r = |v;
      OP_XOR, OP_XNOR: r = ^v;
      default:         r = &v;
    endcase
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_t              op_r_q, op_r_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_red_q, q_red_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic             accept;
  logic             out_xfer;
  logic [CNT_W-1:0] cnt_inc;
  logic [WIDTH-1:0] f_ab;
  logic [WIDTH-1:0] acc_next;
  op_t              op_in;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_xfer  = out_valid_q && out_ready;
  assign op_in     = op_t'(op);
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
  assign f_ab      = apply_op(op_in, a, b);
  assign acc_next  = apply_op(op_r_q, acc_q, a);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    op_r_d      = op_r_q;
    out_valid_d = out_valid_q && !out_xfer;
    q_d         = q_q;
    q_red_d     = q_red_q;
    beat_cnt_d  = beat_cnt_q;

    if (accept) begin
      case (state_q)
        S_IDLE: begin
          if (!in_acc || in_last) begin
            q_d         = f_ab;
            q_red_d     = reduce_op(op_in, f_ab);
            beat_cnt_d  = CNT_ONE;
            out_valid_d = 1'b1;
          end else begin
            acc_d   = f_ab;
            op_r_d  = op_in;
            cnt_d   = CNT_ONE;
            state_d = S_ACC;
          end
        end
        S_ACC: begin
          acc_d = acc_next;
          cnt_d = cnt_inc;
          if (in_last) begin
            q_d         = acc_next;
            q_red_d     = reduce_op(op_r_q, acc_next);
            beat_cnt_d  = cnt_inc;
            out_valid_d = 1'b1;
            state_d     = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      op_r_q      <= OP_AND;
      out_valid_q <= 1'b0;
      q_q         <= '0;
      q_red_q     <= 1'b0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      op_r_q      <= op_r_d;
      out_valid_q <= out_valid_d;
      q_q         <= q_d;
      q_red_q     <= q_red_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign q         = q_q;
  assign q_red     = q_red_q;
  assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_logic_unit.sv
// Scoreboard bench for logic_unit: a default instance and a CNT_W=2 instance
// share stimulus; a burst-folding reference model feeds an expected queue.
module tb_logic_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_acc = 1'b0;
  logic       in_last = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [2:0] op = '0;

  logic       in_ready0, in_ready1, out_valid0, out_valid1, q_red0, q_red1;
  logic [7:0] q0, q1;
  logic [3:0] bc0;
  logic [1:0] bc1;

  always #5 clk = ~clk;

  logic_unit #(.WIDTH(8), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .op(op), .in_acc(in_acc), .in_last(in_last),
    .out_valid(out_valid0), .out_ready(out_ready), .q(q0), .q_red(q_red0),
    .beat_cnt(bc0)
  );

  logic_unit #(.WIDTH(8), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .op(op), .in_acc(in_acc), .in_last(in_last),
    .out_valid(out_valid1), .out_ready(out_ready), .q(q1), .q_red(q_red1),
    .beat_cnt(bc1)
  );

  typedef struct {
    logic [7:0] q;
    logic       red;
    int         cnt;
  } exp_t;

  exp_t       expq[$];
  int         checks = 0;
  int         errors = 0;
  int         rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled
  bit         in_burst = 0;
  logic [2:0] bop;
  logic [7:0] b0;
  logic [7:0] vals[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_f(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    case (o)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return x ^ y;
      3'd3:    return ~(x & y);
      3'd4:    return ~(x | y);
      3'd5:    return ~(x ^ y);
      3'd6:    return x & ~y;
      default: return x;
    endcase
  endfunction

  function automatic logic ref_red(input logic [2:0] o, input logic [7:0] v);
    if (o == 3'd1 || o == 3'd4) return |v;
    if (o == 3'd2 || o == 3'd5) return ^v;
    return &v;
  endfunction

  function automatic int sat(input int c, input int m);
    return (c > m) ? m : c;
  endfunction

  // Reference: collect the burst's beats, fold them when the last one arrives.
  task automatic model_accept();
    exp_t       e;
    logic [7:0] r;
    if (!in_burst) begin
      if (!in_acc || in_last) begin
        e.q = ref_f(op, a, b); e.red = ref_red(op, e.q); e.cnt = 1;
        expq.push_back(e);
      end else begin
        in_burst = 1; bop = op; b0 = b;
        vals.delete(); vals.push_back(a);
      end
    end else begin
      vals.push_back(a);
      if (in_last) begin
        r = ref_f(bop, vals[0], b0);
        for (int i = 1; i < vals.size(); i++) r = ref_f(bop, r, vals[i]);
        e.q = r; e.red = ref_red(bop, r); e.cnt = vals.size();
        expq.push_back(e);
        in_burst = 0;
      end
    end
  endtask

  task automatic set_ready();
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  endtask

  task automatic send(input logic [7:0] a_i, input logic [7:0] b_i, input logic [2:0] op_i,
                      input logic acc_i, input logic last_i);
    int tries = 0;
    bit done = 0;
    while (!done) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a = a_i; b = b_i; op = op_i; in_acc = acc_i; in_last = last_i;
      set_ready();
      @(negedge clk);
      if (in_ready0) begin
        done = 1;
        model_accept();
      end else if (++tries > 100) begin
        chk("accept_timeout", 0, 1);
        done = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      set_ready();
    end
  endtask

  task automatic drain();
    int t = 0;
    rdy_mode = 0;
    while (expq.size() != 0 && t < 300) begin
      idle(1);
      t++;
    end
    if (expq.size() != 0) chk("drain_timeout", expq.size(), 0);
    idle(1);
  endtask

  task automatic do_reset(input int n);
    drain();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; a = 8'h5A; b = 8'hA5; op = 3'd1;
    in_acc = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    in_burst = 0; vals.delete();
    @(negedge clk);
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_out_valid_sat", out_valid1, 0);
    chk("rst_q", q0, 0);
    chk("rst_q_red", q_red0, 0);
    chk("rst_beat_cnt", bc0, 0);
    chk("rst_in_ready", in_ready0, 1);
  endtask

  // Monitor: pops on every output transfer, and checks hold-stability under stall.
  logic [7:0] pq;
  logic [3:0] pbc;
  logic       pred;
  bit         stalled = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stalled = 0;
    end else begin
      if (stalled) begin
        chk("hold_valid", out_valid0, 1);
        chk("hold_q", q0, pq);
        chk("hold_q_red", q_red0, pred);
        chk("hold_beat_cnt", bc0, pbc);
      end
      if (out_valid0 && out_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_output", 0, 1);
        end else begin
          e = expq.pop_front();
          chk("q", q0, e.q);
          chk("q_red", q_red0, e.red);
          chk("beat_cnt", bc0, sat(e.cnt, 15));
          chk("sat_valid", out_valid1, 1);
          chk("sat_q", q1, e.q);
          chk("sat_q_red", q_red1, e.red);
          chk("sat_beat_cnt", bc1, sat(e.cnt, 3));
        end
      end
      stalled = out_valid0 && !out_ready;
      pq = q0; pbc = bc0; pred = q_red0;
    end
  end

  initial begin
    do_reset(2);

    rdy_mode = 0;
    send(8'hF0, 8'h3C, 3'd0, 1'b0, 1'b0);
    idle(1);
    @(negedge clk);
    chk("latency_valid", out_valid0, 1);

    send(8'h01, 8'h02, 3'd2, 1'b1, 1'b0);
    send(8'h04, 8'hFF, 3'd0, 1'b0, 1'b0);
    send(8'h08, 8'h00, 3'd2, 1'b1, 1'b1);
    idle(1);
    @(negedge clk);
    chk("burst_valid", out_valid0, 1);

    rdy_mode = 2;
    send(8'hAA, 8'h55, 3'd1, 1'b0, 1'b0);
    repeat (3) begin
      idle(1);
      @(negedge clk);
      chk("bp_in_ready", in_ready0, 0);
    end
    rdy_mode = 0;
    send(8'h0F, 8'h33, 3'd2, 1'b0, 1'b0);
    idle(1);
    @(negedge clk);
    chk("no_bubble_valid", out_valid0, 1);

    send(8'h11, 8'h22, 3'd1, 1'b1, 1'b0);
    send(8'h44, 8'h00, 3'd1, 1'b1, 1'b0);
    do_reset(1);
    send(8'h01, 8'h80, 3'd1, 1'b0, 1'b0);

    send(8'h01, 8'h00, 3'd1, 1'b1, 1'b0);
    send(8'h02, 8'h00, 3'd1, 1'b1, 1'b0);
    send(8'h04, 8'h00, 3'd1, 1'b1, 1'b0);
    send(8'h08, 8'h00, 3'd1, 1'b1, 1'b0);
    send(8'h10, 8'h00, 3'd1, 1'b1, 1'b1);

    rdy_mode = 1;
    for (int i = 0; i < 18; i++)
      send(8'($urandom), 8'($urandom), 3'd2, 1'b1, 1'(i == 17));

    for (int i = 0; i < 400; i++) begin
      send(8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 4) == 0) idle(1);
    end

    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
